// File: rtl/vga_controller_if.sv
// vga_controller_if: RGB332 colour and active-low sync lines of the VGA connector.
interface vga_controller_if;
    logic [2:0] vgaRed;
    logic [2:0] vgaGreen;
    logic [1:0] vgaBlue;
    logic       h_sync;
    logic       v_sync;
    modport master (output vgaRed, vgaGreen, vgaBlue, h_sync, v_sync);
    modport slave  (input  vgaRed, vgaGreen, vgaBlue, h_sync, v_sync);
endinterface

// File: rtl/vga_controller.sv
// vga_controller: 640x480@60 VGA timing and 8-colour bar pattern, all outputs registered.
// Define VGA_BORDER_EN to overlay a 1-pixel white border on the visible area.
module vga_controller #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input logic             clk,
    input logic             rst_n,
    vga_controller_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW      = H_VISIBLE / 8;
    localparam logic [7:0] PAL [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [7:0]    rgb_q, rgb_d;
    logic          hs_q, hs_d, vs_q, vs_d;
    logic          pix_tick, h_end, v_end, visible;
    logic [2:0]    bar;

    always_comb begin
        pix_tick = div_q == DW'(CLK_DIV - 1);
        div_d    = pix_tick ? '0 : div_q + DW'(1);
        h_end    = h_cnt_q == 10'(H_TOTAL - 1);
        v_end    = v_cnt_q == 10'(V_TOTAL - 1);
        h_cnt_d  = !pix_tick ? h_cnt_q : h_end ? '0 : h_cnt_q + 10'd1;
        v_cnt_d  = !(pix_tick && h_end) ? v_cnt_q : v_end ? '0 : v_cnt_q + 10'd1;
        hs_d     = !(h_cnt_q >= 10'(H_VISIBLE + H_FP) && h_cnt_q < 10'(H_VISIBLE + H_FP + H_SYNC));
        vs_d     = !(v_cnt_q >= 10'(V_VISIBLE + V_FP) && v_cnt_q < 10'(V_VISIBLE + V_FP + V_SYNC));
        visible  = h_cnt_q < 10'(H_VISIBLE) && v_cnt_q < 10'(V_VISIBLE);
        // bar index = h_cnt / BW via a comparator chain rather than a divider
        bar = h_cnt_q >= 10'(7 * BW) ? 3'd7 :
              h_cnt_q >= 10'(6 * BW) ? 3'd6 :
              h_cnt_q >= 10'(5 * BW) ? 3'd5 :
              h_cnt_q >= 10'(4 * BW) ? 3'd4 :
              h_cnt_q >= 10'(3 * BW) ? 3'd3 :
              h_cnt_q >= 10'(2 * BW) ? 3'd2 :
              h_cnt_q >= 10'(BW)     ? 3'd1 : 3'd0;
`ifdef VGA_BORDER_EN
        rgb_d = !visible ? 8'h00 :
                (h_cnt_q == 10'd0 || h_cnt_q == 10'(H_VISIBLE - 1) ||
                 v_cnt_q == 10'd0 || v_cnt_q == 10'(V_VISIBLE - 1)) ? 8'hFF : PAL[bar];
`else
        rgb_d = visible ? PAL[bar] : 8'h00;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            div_q   <= div_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

    assign vga.vgaRed   = rgb_q[7:5];
    assign vga.vgaGreen = rgb_q[4:2];
    assign vga.vgaBlue  = rgb_q[1:0];
    assign vga.h_sync   = hs_q;
    assign vga.v_sync   = vs_q;
endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller: directed pixel vectors checked by a scoreboard monitor, plus sync timing checks.
module tb_vga_controller;
    localparam int CLK_DIV = 4;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
`ifdef VGA_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    typedef struct {
        int         n;
        int         v;
        int         h;
        logic [9:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    vga_controller_if vga();

    vga_controller #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vga(vga)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_cmp = 0, n_fail = 0;
    bit   run = 1'b0;
    int   k = 0;
    int   hs_falls = 0, hs_fall_k = 0, vs_falls = 0, vs_rises = 0, vs_fall_k = 0, hs_in_vs = 0;
    logic hs_p = 1'b1, vs_p = 1'b1;

    wire [7:0] rgb = {vga.vgaRed, vga.vgaGreen, vga.vgaBlue};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // expected {rgb, h_sync, v_sync} for pixel (v,h); rb is the border-build colour
    task automatic push(input int v, input int h, input logic [7:0] rp, input logic [7:0] rb,
                        input logic hs, input logic vs);
        exp_t e;
        e.n = v * 800 + h;
        e.v = v;
        e.h = h;
        e.exp = {BORDER ? rb : rp, hs, vs};
        q.push_back(e);
    endtask

    always @(posedge clk) if (run) k++;

    always @(negedge clk) begin
        if (run && k >= 1) begin
            int   n, ph;
            exp_t e;
            n  = (k - 1) / CLK_DIV;
            ph = (k - 1) % CLK_DIV;
            if (q.size() != 0 && q[0].n == n && ph == 1) begin
                e = q.pop_front();
                n_cmp++;
                if ({rgb, vga.h_sync, vga.v_sync} !== e.exp) begin
                    n_fail++;
                    $display("FAIL pixel v=%0d h=%0d: got rgb=%0h hs=%0b vs=%0b expected rgb=%0h hs=%0b vs=%0b",
                             e.v, e.h, rgb, vga.h_sync, vga.v_sync, e.exp[9:2], e.exp[1], e.exp[0]);
                end
            end
            if (hs_p && !vga.h_sync) begin
                if (hs_falls == 0) chk("h_first_fall_clk", k, 4 * 656 + 1);
                else chk("h_period_clk", k - hs_fall_k, 3200);
                hs_falls++;
                hs_fall_k = k;
                if (!vga.v_sync) hs_in_vs++;
            end
            if (!hs_p && vga.h_sync && hs_falls > 0) chk("h_low_width_clk", k - hs_fall_k, 384);
            if (vs_p && !vga.v_sync) begin
                if (vs_falls == 0) chk("v_first_fall_clk", k, 4 * 800 * (VV + VF) + 1);
                else chk("v_period_clk", k - vs_fall_k, 3200 * (VV + VF + VS + VB));
                vs_falls++;
                vs_fall_k = k;
                hs_in_vs = 0;
            end
            if (!vs_p && vga.v_sync && vs_falls > 0) begin
                chk("v_low_width_clk", k - vs_fall_k, 6400);
                chk("h_falls_in_vsync", hs_in_vs, 2);
                vs_rises++;
            end
        end
        hs_p = vga.h_sync;
        vs_p = vga.v_sync;
    end

    initial begin
        push(0,   0, 8'hFF, 8'hFF, 1, 1);
        push(0,  79, 8'hFF, 8'hFF, 1, 1);
        push(0,  80, 8'hFC, 8'hFF, 1, 1);
        push(0, 160, 8'h1F, 8'hFF, 1, 1);
        push(0, 240, 8'h1C, 8'hFF, 1, 1);
        push(0, 320, 8'hE3, 8'hFF, 1, 1);
        push(0, 400, 8'hE0, 8'hFF, 1, 1);
        push(0, 480, 8'h03, 8'hFF, 1, 1);
        push(0, 560, 8'h00, 8'hFF, 1, 1);
        push(0, 639, 8'h00, 8'hFF, 1, 1);
        push(0, 640, 8'h00, 8'h00, 1, 1);
        push(0, 655, 8'h00, 8'h00, 1, 1);
        push(0, 656, 8'h00, 8'h00, 0, 1);
        push(0, 751, 8'h00, 8'h00, 0, 1);
        push(0, 752, 8'h00, 8'h00, 1, 1);
        push(0, 799, 8'h00, 8'h00, 1, 1);
        push(1,   0, 8'hFF, 8'hFF, 1, 1);
        push(1, 100, 8'hFC, 8'hFC, 1, 1);
        push(1, 560, 8'h00, 8'h00, 1, 1);
        push(1, 639, 8'h00, 8'hFF, 1, 1);
        push(2, 300, 8'h1C, 8'h1C, 1, 1);
        push(2, 639, 8'h00, 8'hFF, 1, 1);
        push(3, 200, 8'h1F, 8'hFF, 1, 1);
        push(3, 700, 8'h00, 8'h00, 0, 1);
        push(4,   0, 8'h00, 8'h00, 1, 1);
        push(4, 400, 8'h00, 8'h00, 1, 1);
        push(5,   0, 8'h00, 8'h00, 1, 0);
        push(5, 656, 8'h00, 8'h00, 0, 0);
        push(6, 799, 8'h00, 8'h00, 1, 0);
        push(7,   0, 8'h00, 8'h00, 1, 1);
        push(8,   0, 8'hFF, 8'hFF, 1, 1);
        push(8, 480, 8'h03, 8'hFF, 1, 1);
        push(13, 10, 8'h00, 8'h00, 1, 0);

        #100;
        chk("reset_hold_rgb", rgb, 8'h00);
        chk("reset_hold_hsync", vga.h_sync, 1'b1);
        chk("reset_hold_vsync", vga.v_sync, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;
        while ((q.size() != 0 || vs_rises < 2) && k < 60000) @(negedge clk);
        if (q.size() != 0 || vs_rises < 2) begin
            n_cmp++;
            n_fail++;
            $display("FAIL run_budget: got %0d pending vectors and %0d vsync pulses, required 0 and 2", q.size(), vs_rises);
        end

        // frame 3, line 0, pixel 100
        while (k < 4 * 12900 + 2) @(negedge clk);
        chk("pre_reset_rgb", rgb, BORDER ? 8'hFF : 8'hFC);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_rgb", rgb, 8'h00);
        chk("async_reset_vsync", vga.v_sync, 1'b1);
        run = 1'b0;

        #20;
        @(negedge clk);
        k = 0;
        hs_falls = 0;
        vs_falls = 0;
        vs_rises = 0;
        rst_n = 1'b1;
        run = 1'b1;
        while (k < 4 * 700 + 2) @(negedge clk);
        chk("restart_hsync_low", vga.h_sync, 1'b0);
        chk("restart_h_falls", hs_falls, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_hsync", vga.h_sync, 1'b1);
        chk("async_reset_rgb2", rgb, 8'h00);
        run = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_controller.md
Name: vga_controller

Overview:
- Self-contained 640x480 @ 60 Hz VGA timing generator and test-pattern source for the board's 8-bit (RGB332) VGA connector.
- Divides the 100 MHz system clock down to a 25 MHz pixel enable.
- Produces active-low h_sync and v_sync, plus an 8-colour vertical bar pattern in the visible area and black during blanking.

Parameters:
- CLK_DIV, 4, system clocks per pixel; must be ≥1.
- H_VISIBLE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_VISIBLE, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.

Ports:
- clk  input  1  100 MHz system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- vgaRed  output  3  red intensity.
- vgaGreen  output  3  green intensity.
- vgaBlue  output  2  blue intensity.
- h_sync  output  1  horizontal sync, active low.
- v_sync  output  1  vertical sync, active low.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n=0: divider, h_cnt and v_cnt = 0; h_sync=1, v_sync=1; all colour outputs = 0.
- Pixel enable:
  - Divider counts 0..CLK_DIV-1 and wraps.
  - pix_tick is asserted for the one clk where the divider = CLK_DIV-1, i.e. one clk in 4 by default.
- Counters:
  - h_cnt advances only on pix_tick, range 0..H_TOTAL-1 (800); wraps to 0.
  - v_cnt increments on the pix_tick where h_cnt wraps, range 0..V_TOTAL-1 (525); wraps to 0 together with h_cnt at end of frame.
  - Counter widths: 10 bits each.
- Sync decode:
  - h_sync = 0 iff H_VISIBLE+H_FP ≤ h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751).
  - v_sync = 0 iff V_VISIBLE+V_FP ≤ v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491).
- Colour decode:
  - Visible region: h_cnt < 640 and v_cnt < 480. Outside it, all colour outputs = 0.
  - Inside it, bar = h_cnt/80 (comparator chain; no divider). RGB332 value {vgaRed, vgaGreen, vgaBlue} per bar:
    - bar 0 white FF
    - bar 1 yellow FC
    - bar 2 cyan 1F
    - bar 3 green 1C
    - bar 4 magenta E3
    - bar 5 red E0
    - bar 6 blue 03
    - bar 7 black 00
- Latency: all outputs are registered; they reflect counter values with exactly 1 clk latency after a counter update. Syncs and colours stay aligned with each other.
- Frame timing:
  - Line = 800×CLK_DIV = 3200 clk.
  - Frame = 525 lines = 1,680,000 clk = 16.8 ms.
- Reset mid-frame: outputs return immediately (asynchronously) to reset values. After release, timing restarts at h_cnt=0, v_cnt=0; the first pix_tick occurs CLK_DIV clks after release.

Optional Feature:
- Macro: VGA_BORDER_EN.
- When defined: a 1-pixel white border (FF) overrides the bar colour wherever h_cnt ∈ {0, 639} or v_cnt ∈ {0, 479} inside the visible region.
- When undefined: pure bar pattern; no border logic is synthesised.
- Sync timing is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 100 ns with clk running → h_sync=1, v_sync=1, RGB=00. Assert rst_n=0 mid-line → same values without waiting for a clk edge.
- Horizontal timing: after release, measure h_sync → falling edges 32,000 ns apart (3200 clk); low width 3840 ns (384 clk); first fall at h_cnt=656.
- Vertical timing: run 2 frames → v_sync low for exactly 2 lines (6400 clk); falling edges 1,680,000 clk apart; h_sync keeps toggling during v_sync low.
- Colour bars, line 0: sample RGB at h_cnt 0, 80, 160, 240, 320, 400, 480, 560 → FF, FC, 1F, 1C, E3, E0, 03, 00; at h_cnt 79 → FF, at h_cnt 80 → FC.
- Blanking: h_cnt 640..799 on any line, and every pixel on v_cnt 480..524 → RGB=00.
- With VGA_BORDER_EN defined: h_cnt=560 on v_cnt=0 → FF; on v_cnt=100 → 00; h_cnt=639, v_cnt=200 → FF.
